conv_encoder_framer: RTL and testbench

//  Rate-1/2, K=3 convolutional encoder and frame terminator; the stage directly upstream of the Viterbi decoder.
//  - Accepts a serial bit stream over valid/ready.
//  - Emits one 2-bit code symbol per accepted bit; this symbol drives the decoder's encoded_signal[1:0].
//  - Appends K-1=2 zero tail bits per frame so the trellis terminates in state 0.

---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/conv_err_inject.sv | 35 +++
 rtl/conv_encoder_framer.sv | 156 +++++++++++++++
 tb/tb_conv_encoder_framer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, state encoding and the K=3 encoder kernel used by the
// convolutional encoder/framer that feeds the Viterbi decoder.
package viterbi_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  // Tap vector is {u, sr[0], sr[1]}; returns {c1, c0}.
  function automatic logic [1:0] conv_symbol(
    input logic [K-1:0] g0,
    input logic [K-1:0] g1,
    input logic         u,
    input logic [K-2:0] sr
  );
    logic [K-1:0] taps;
    taps = {u, sr[0], sr[1]};
    return {^(g0 & taps), ^(g1 & taps)};
  endfunction

endpackage

// File: rtl/conv_err_inject.sv
// Periodic c0 corruption for decoder stress testing; the whole module only
// exists when CONV_ERR_INJECT_EN is defined.
`ifdef CONV_ERR_INJECT_EN
module conv_err_inject #(
  parameter int ERR_PERIOD = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       err_en,
  input  logic       load,
  input  logic [1:0] sym_in,
  output logic [1:0] sym_out
);

  localparam int              CW  = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
  localparam logic [CW-1:0]   HIT = CW'(ERR_PERIOD - 1);

  logic [CW-1:0] sym_cnt;
  logic          hit;

  assign hit     = err_en && (sym_cnt == HIT);
  assign sym_out = {sym_in[1], sym_in[0] ^ hit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_cnt <= '0;
    end else if (!err_en) begin
      sym_cnt <= '0;
    end else if (load) begin
      sym_cnt <= hit ? '0 : sym_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=3 convolutional encoder with frame termination (2 zero tail bits).
// Optional periodic error injection is compiled in with CONV_ERR_INJECT_EN.
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int           FRAME_LEN  = 16,
  parameter logic [K-1:0] G0         = G0_DEFAULT,
  parameter logic [K-1:0] G1         = G1_DEFAULT,
  parameter int           ERR_PERIOD = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [1:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       code_sof,
  output logic       code_eof,
  output logic       busy,
  input  logic       err_en
);

  localparam int            CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN_M1    = CW'(FRAME_LEN - 1);
  localparam int            TW        = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_LEN - 1);

  enc_state_t    state, next_state;
  logic [K-2:0]  sr;
  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] tail_idx;

  logic       out_free;
  logic       xfer;
  logic       tail_load;
  logic       load;
  logic       u;
  logic       sym_sof;
  logic       sym_eof;
  logic [1:0] enc_sym;
  logic [1:0] sym;

  assign out_free = !code_valid || code_ready;
  assign xfer     = din_valid && din_ready;
  assign load     = xfer || tail_load;
  assign busy     = (state != IDLE) || code_valid;
  assign enc_sym  = conv_symbol(G0, G1, u, sr);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (xfer) next_state = (din_last || FRAME_LEN == 1) ? TAIL : DATA;
      DATA: if (xfer) next_state = (din_last || bit_cnt == LEN_M1) ? TAIL : DATA;
      TAIL: if (tail_load && tail_idx == TAIL_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath-control decode. din_ready is also held low while reset
  // is asserted so every output reads 0 during reset.
  always_comb begin
    din_ready = 1'b0;
    tail_load = 1'b0;
    u         = 1'b0;
    sym_sof   = 1'b0;
    sym_eof   = 1'b0;
    unique case (state)
      IDLE: begin
        din_ready = reset && out_free;
        u         = din;
        sym_sof   = 1'b1;
      end
      DATA: begin
        din_ready = reset && out_free;
        u         = din;
      end
      TAIL: begin
        tail_load = out_free;
        sym_eof   = (tail_idx == TAIL_LAST);
      end
      default: ;
    endcase
  end

  // Shift register, info-bit count and tail position advance only on a load,
  // so output stalls freeze the whole encoder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr       <= '0;
      bit_cnt  <= '0;
      tail_idx <= '0;
    end else if (load) begin
      sr <= {sr[K-3:0], u};
      unique case (state)
        IDLE: bit_cnt <= CW'(1);
        DATA: bit_cnt <= bit_cnt + 1'b1;
        TAIL: begin
          tail_idx <= sym_eof ? '0 : tail_idx + 1'b1;
          if (sym_eof) bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_ERR_INJECT_EN
  conv_err_inject #(
    .ERR_PERIOD(ERR_PERIOD)
  ) u_err_inject (
    .clk    (clk),
    .reset  (reset),
    .err_en (err_en),
    .load   (load),
    .sym_in (enc_sym),
    .sym_out(sym)
  );
`else
  logic unused_cfg;
  assign unused_cfg = err_en ^ (ERR_PERIOD == 0);
  assign sym        = enc_sym;
`endif

  // Single output register stage; holds its contents while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_out   <= '0;
      code_valid <= 1'b0;
      code_sof   <= 1'b0;
      code_eof   <= 1'b0;
    end else if (load) begin
      code_out   <= sym;
      code_valid <= 1'b1;
      code_sof   <= sym_sof;
      code_eof   <= sym_eof;
    end else if (out_free) begin
      code_valid <= 1'b0;
      code_sof   <= 1'b0;
      code_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer: hand vectors, multi-cycle corner
// sequences and random streams against a convolution-sum reference model.
module tb_conv_encoder_framer;

  localparam int FRAME_LEN  = 16;
  localparam int ERR_PERIOD = 7;
  localparam int TAILN      = 2;
`ifdef CONV_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       din, din_valid, din_last, din_ready;
  logic [1:0] code_out;
  logic       code_valid, code_ready, code_sof, code_eof, busy, err_en;

  conv_encoder_framer #(
    .FRAME_LEN (FRAME_LEN),
    .ERR_PERIOD(ERR_PERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .code_sof  (code_sof),
    .code_eof  (code_eof),
    .busy      (busy),
    .err_en    (err_en)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit         in_bits[$];
  bit         in_last[$];
  logic [3:0] got_q[$];   // {code_out, sof, eof}
  int         got_cyc[$];
  logic [3:0] exp_q[$];
  int         err_k;

  typedef struct {
    int         n;
    bit [3:0]   bits;     // bits[0] is sent first; last flag on bit n-1
    logic [1:0] exp [6];  // n+2 symbols
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: c1 = x[t]^x[t-1]^x[t-2], c0 = x[t]^x[t-2] over the frame
  // padded with two zero tail bits.
  function automatic int xbit(input int start, input int len, input int t);
    if (t < 0 || t >= len) return 0;
    return int'(in_bits[start + t]);
  endfunction

  function automatic void emit_frame(input int start, input int len, input bit closed,
                                     input bit inject);
    int   total, a, b, c;
    logic c1, c0;
    total = closed ? len + TAILN : len;
    for (int t = 0; t < total; t++) begin
      a  = xbit(start, len, t);
      b  = xbit(start, len, t - 1);
      c  = xbit(start, len, t - 2);
      c1 = ((a + b + c) % 2) == 1;
      c0 = ((a + c) % 2) == 1;
      if (inject) begin
        if (err_k == ERR_PERIOD - 1) begin
          c0    = ~c0;
          err_k = 0;
        end else begin
          err_k++;
        end
      end
      exp_q.push_back({c1, c0, t == 0, closed && (t == total - 1)});
    end
  endfunction

  function automatic void build_expected(input bit inject);
    int start;
    exp_q.delete();
    err_k = 0;
    start = 0;
    for (int i = 0; i < in_bits.size(); i++) begin
      if (in_last[i] || (i - start + 1) == FRAME_LEN) begin
        emit_frame(start, i - start + 1, 1'b1, inject);
        start = i + 1;
      end
    end
    if (start < in_bits.size()) emit_frame(start, in_bits.size() - start, 1'b0, inject);
  endfunction

  // Called #1 after a rising edge; drives the queued bits and collects symbols.
  task automatic run_stream(input int stall_pct, input int n_expect, input int budget,
                            input string tag);
    int         idx;
    logic       hold;
    logic [3:0] held;
    idx  = 0;
    hold = 1'b0;
    held = '0;
    got_q.delete();
    got_cyc.delete();
    for (int cyc = 0; cyc < budget && got_q.size() < n_expect; cyc++) begin
      din_valid = (idx < in_bits.size());
      din       = 1'b0;
      din_last  = 1'b0;
      if (din_valid) begin
        din      = in_bits[idx];
        din_last = in_last[idx];
      end
      code_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (hold) check({tag, " stall hold"}, {code_valid, code_out, code_sof, code_eof},
                      {1'b1, held});
      hold = code_valid && !code_ready;
      held = {code_out, code_sof, code_eof};
      if (din_valid && din_ready) idx++;
      if (code_valid && code_ready) begin
        got_q.push_back({code_out, code_sof, code_eof});
        got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
    din_valid  = 1'b0;
    din_last   = 1'b0;
    code_ready = 1'b1;
    check({tag, " symbol count"}, got_q.size(), n_expect);
  endtask

  task automatic compare_q(input string tag);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s sym%0d", tag, i + 1), got_q[i], exp_q[i]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int n, input bit [3:0] bits);
    in_bits.delete();
    in_last.delete();
    for (int i = 0; i < n; i++) begin
      in_bits.push_back(bits[i]);
      in_last.push_back(i == n - 1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4, 4'b1101, '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11}};
    vt[1] = '{1, 4'b0001, '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00}};
    vt[2] = '{1, 4'b0000, '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}};
    vt[3] = '{2, 4'b0010, '{2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00}};
    vt[4] = '{3, 4'b0111, '{2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00}};

    reset      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    code_ready = 1'b1;
    err_en     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {din_ready, code_valid, code_out, code_sof, code_eof, busy}, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle busy", busy, 1'b0);
    check("idle din_ready", din_ready, 1'b1);

    // Hand vectors, one closed frame each
    foreach (vt[e]) begin
      load_frame(vt[e].n, vt[e].bits);
      run_stream(0, vt[e].n + TAILN, 60, $sformatf("vec%0d", e));
      for (int i = 0; i < vt[e].n + TAILN && i < got_q.size(); i++)
        check($sformatf("vec%0d sym%0d", e, i + 1), got_q[i],
              {vt[e].exp[i], i == 0, i == vt[e].n + TAILN - 1});
      check($sformatf("vec%0d busy after", e), busy, 1'b0);
    end

    // 20 bits, no din_last: tail forced after bit 16, bits 17-20 open a frame
    in_bits.delete();
    in_last.delete();
    for (int i = 0; i < 20; i++) begin
      in_bits.push_back(1'($urandom_range(1)));
      in_last.push_back(1'b0);
    end
    build_expected(1'b0);
    run_stream(0, exp_q.size(), 100, "len20");
    compare_q("len20");
    check("len20 second sof", got_q.size() > 18 ? 32'(got_q[18][1]) : 32'd0, 32'd1);

    // Mid-frame reset: outputs clear immediately, next frame restarts from sr=00
    apply_reset();
    load_frame(2, 4'b0011);
    in_last[1] = 1'b0;
    run_stream(0, 2, 20, "pre-reset");
    din        = 1'b1;
    din_valid  = 1'b1;
    code_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset valid", code_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("async reset outputs",
          {din_ready, code_valid, code_out, code_sof, code_eof, busy}, '0);
    din_valid  = 1'b0;
    code_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    load_frame(1, 4'b0001);
    run_stream(0, 3, 20, "post-reset");
    build_expected(1'b0);
    compare_q("post-reset");

    // Random stalls on the 1,0,1,1 frame
    for (int r = 0; r < 3; r++) begin
      load_frame(4, 4'b1101);
      build_expected(1'b0);
      run_stream(50, exp_q.size(), 200, $sformatf("stall%0d", r));
      compare_q($sformatf("stall%0d", r));
    end

    // Back-to-back single-bit frames with zero bubble
    in_bits   = '{1'b1, 1'b1};
    in_last   = '{1'b1, 1'b1};
    exp_q     = '{4'b1110, 4'b1000, 4'b1101, 4'b1110, 4'b1000, 4'b1101};
    run_stream(0, 6, 40, "b2b");
    compare_q("b2b");
    check("b2b sof after eof", got_q.size() == 6 ? got_cyc[3] - got_cyc[2] : -1, 1);

    // Error injection: 16 zeros -> c0 flipped on symbols 7 and 14 when enabled
    err_en = 1'b1;
    in_bits.delete();
    in_last.delete();
    for (int i = 0; i < 16; i++) begin
      in_bits.push_back(1'b0);
      in_last.push_back(1'b0);
    end
    build_expected(INJ);
    run_stream(0, exp_q.size(), 80, "errinj");
    compare_q("errinj");
    err_en = 1'b0;

    // Random multi-frame streams with random stalls
    for (int r = 0; r < 4; r++) begin
      in_bits.delete();
      in_last.delete();
      for (int i = 0; i < 40; i++) begin
        in_bits.push_back(1'($urandom_range(1)));
        in_last.push_back(($urandom_range(5) == 0) || i == 39);
      end
      build_expected(1'b0);
      run_stream(35, exp_q.size(), 600, $sformatf("rand%0d", r));
      compare_q($sformatf("rand%0d", r));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
